mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one Mux4w 1-bit channel among four requesters.
//  Arbitrates req[3:0], holds the winner for a bounded burst, and drives Mux4w's
//  sel[1:0] so the winner's input reaches the shared output.
//  Sits beside the Mux4w instance; grant/last go back to the requesters.
// PARAMETERS
//  MAXBEAT  8  max consecutive cycles one requester may hold the channel (2..2^CNTW)
//  CNTW     4  width of beat counter
// PORTS
//  clk    input   1     single clock, rising edge
//  rst    input   1     asynchronous, active-high reset
//  req    input   4     req[i]=1: requester i wants channel (level, held until done)
//  grant  output  4     one-hot owner; all zero when idle (registered)
//  sel    output  2     Mux4w select for current owner (registered)
//  busy   output  1     |grant
//  last   output  1     current beat is owner's final allowed beat
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant=0, sel=2'b00, busy=0, last=0,
//   cnt=0, ptr=0 (requester 0 highest priority first). Reset mid-burst drops grant at once.
//  sel encoding (fixed): owner0->2'b01, owner1->2'b11, owner2->2'b00, owner3->2'b10;
//   sel holds last owner's code while IDLE.
//  Pick rule: first i with req[i]=1 scanning ptr, ptr+1, .. ptr+3 (mod 4).
//  States: IDLE, GRANT.
//  IDLE: if |req at edge -> GRANT, grant=onehot(pick), sel=code(pick), cnt=0.
//   Latency req->grant = 1 cycle. No req -> stay IDLE.
//  GRANT: each edge with req[owner]=1 and cnt<MAXBEAT-1 -> cnt+1, hold owner.
//   Release when req[owner]=0 at edge, or cnt==MAXBEAT-1 at edge (burst expiry).
//   On release: ptr=owner+1 mod 4; pick recomputed with new ptr, masking owner
//   only when release was by expiry and another req is pending.
//   If a pick exists -> stay GRANT with new owner, cnt=0 (no idle bubble);
//   else -> IDLE, grant=0.
//  Expiry with owner as sole requester: owner re-granted, cnt=0.
//  last = (state==GRANT) && (cnt==MAXBEAT-1); combinational from registers.
//  Beat accounting: a cycle counts as a beat only when grant[i]=1 and req[i]=1;
//   a cycle where owner has already dropped req is a dead cycle, not a beat.
//  Requests arriving mid-burst wait; never preempt. grant always one-hot or zero.
//  cnt width CNTW; never wraps (release at MAXBEAT-1).
// TESTING
//  1 reset, req=0001 -> next edge grant=0001, sel=01, busy=1; drop req -> grant=0 next edge.
//  2 req=1111 held, MAXBEAT=8 -> owners 0,1,2,3,0 each 8 cycles, last on 8th, no gaps.
//  3 owner 2 alone holds 20 cycles -> re-granted every 8 cycles, last pulses at cnt=7.
//  4 owner 1 granted, req=0011 then drop req[1] -> next owner 0 (ptr=2 wraps), sel=01.
//  5 rst pulse mid-burst (cnt=3) -> grant=0,sel=00,last=0 same cycle; ptr=0 after.
//  6 idle with sel=10 (owner3 last) -> sel stays 10 while grant=0, busy=0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one Mux4w 1-bit channel among four requesters.
// Grants a winner for a bounded burst and drives the matching Mux4w select code.
module mux4_rr_arbiter #(
    parameter int MAXBEAT = 8,
    parameter int CNTW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       last
);

    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_GRANT = 1'b1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXBEAT - 1);

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } pick_t;

    // Mux4w input wiring is not in requester order, so the code is a lookup.
    function automatic logic [1:0] sel_code(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = 2'b01;
            2'd1:    code = 2'b11;
            2'd2:    code = 2'b00;
            default: code = 2'b10;
        endcase
        return code;
    endfunction

    function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] p);
        pick_t      res;
        logic [1:0] idx;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!res.valid && r[idx]) begin
                res.valid = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

    logic [0:0]      state, state_nxt;
    logic [1:0]      owner, owner_nxt;
    logic [1:0]      ptr, ptr_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            take;
    logic            expire;
    logic [3:0]      others;
    logic [3:0]      cand;
    pick_t           pick;

    assign others = req & ~(4'b0001 << owner);
    assign expire = req[owner] && (cnt == CNT_LAST);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        take      = 1'b0;
        cand      = req;
        pick      = '0;
        case (state)
            ST_IDLE: begin
                pick = rr_pick(req, ptr);
                if (pick.valid) begin
                    state_nxt = ST_GRANT;
                    owner_nxt = pick.idx;
                    cnt_nxt   = '0;
                    take      = 1'b1;
                end
            end
            default: begin
                if (req[owner] && (cnt != CNT_LAST)) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    // Release: the pointer moves past the owner; an expired owner
                    // is skipped only if someone else is actually waiting.
                    ptr_nxt = owner + 2'd1;
                    if (expire && (|others))
                        cand = others;
                    pick    = rr_pick(cand, ptr_nxt);
                    cnt_nxt = '0;
                    if (pick.valid) begin
                        owner_nxt = pick.idx;
                        take      = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
            grant <= 4'b0000;
            sel   <= 2'b00;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                grant <= 4'b0001 << owner_nxt;
                sel   <= sel_code(owner_nxt);
            end else if (state_nxt == ST_IDLE) begin
                grant <= 4'b0000;
            end
        end
    end

    assign busy = |grant;
    assign last = (state == ST_GRANT) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table, directed burst
// sequences and random requests against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

    localparam int MAXBEAT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       last;

    mux4_rr_arbiter #(.MAXBEAT(MAXBEAT), .CNTW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .busy  (busy),
        .last  (last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       last;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: owner index (-1 = idle), beats used, scan start.
    int sel_tab [4] = '{1, 3, 0, 2};
    int m_owner;
    int m_cnt;
    int m_ptr;
    int m_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_sel   = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] rr;
        int         p;
        bit         expired;
        if (m_owner < 0) begin
            p = pick(r, m_ptr);
            if (p >= 0) begin
                m_owner = p;
                m_cnt   = 0;
                m_sel   = sel_tab[p];
            end
        end else if (r[m_owner] && m_cnt < MAXBEAT - 1) begin
            m_cnt++;
        end else begin
            expired = r[m_owner];
            m_ptr   = (m_owner + 1) % 4;
            rr      = r;
            if (expired && ((r & ~(4'b0001 << m_owner)) != 4'b0000))
                rr[m_owner] = 1'b0;
            p     = pick(rr, m_ptr);
            m_cnt = 0;
            if (p >= 0) begin
                m_owner = p;
                m_sel   = sel_tab[p];
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        check("model_grant", 32'(grant), 32'(eg));
        check("model_sel",   32'(sel),   32'(m_sel));
        check("model_busy",  32'(busy),  32'(m_owner >= 0));
        check("model_last",  32'(last),  32'(m_owner >= 0 && m_cnt == MAXBEAT - 1));
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sel",   32'(sel),   32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_last",  32'(last),  32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t       tbl [9];
    logic [3:0] r;
    int         o;

    initial begin
        tbl[0] = '{4'b0001, 4'b0001, 2'b01, 1'b1, 1'b0};
        tbl[1] = '{4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0};
        tbl[2] = '{4'b1000, 4'b1000, 2'b10, 1'b1, 1'b0};
        tbl[3] = '{4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0};
        tbl[4] = '{4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0};
        tbl[5] = '{4'b0110, 4'b0010, 2'b11, 1'b1, 1'b0};
        tbl[6] = '{4'b0011, 4'b0010, 2'b11, 1'b1, 1'b0};
        tbl[7] = '{4'b0001, 4'b0001, 2'b01, 1'b1, 1'b0};
        tbl[8] = '{4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0};

        rst = 1'b1;
        model_reset();
        #12;
        do_reset();

        // Vector table: single grant, idle sel hold, pointer wrap after drop.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].req);
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            check($sformatf("vec%0d_sel", i),   32'(sel),   32'(tbl[i].sel));
            check($sformatf("vec%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
            check($sformatf("vec%0d_last", i),  32'(last),  32'(tbl[i].last));
        end

        // All four requesting: 8-beat bursts rotating 0,1,2,3,0 with no gaps.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step(4'b1111);
            o = ((k - 1) / MAXBEAT) % 4;
            check($sformatf("rot%0d_grant", k), 32'(grant), 32'(4'b0001 << o));
            check($sformatf("rot%0d_last", k),  32'(last),  32'((k - 1) % MAXBEAT == MAXBEAT - 1));
        end

        // Sole requester 2: re-granted after each expiry, last every 8th beat.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(4'b0100);
            check($sformatf("solo%0d_grant", k), 32'(grant), 32'h4);
            check($sformatf("solo%0d_sel", k),   32'(sel),   32'h0);
            check($sformatf("solo%0d_last", k),  32'(last),  32'((k - 1) % MAXBEAT == MAXBEAT - 1));
        end

        // Reset mid-burst: outputs drop immediately and the pointer returns to 0.
        do_reset();
        step(4'b0001);
        step(4'b0000);
        for (int k = 0; k < 4; k++) step(4'b0101);
        check("pre_rst_grant", 32'(grant), 32'h4);
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_sel",   32'(sel),   32'h0);
        check("midrst_last",  32'(last),  32'h0);
        check("midrst_busy",  32'(busy),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1001);
        check("post_rst_ptr", 32'(grant), 32'h1);

        // Random level requests with occasional toggles, checked by the model.
        do_reset();
        r = 4'b0000;
        for (int k = 0; k < 800; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            step(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
